mem_stage_hs: RTL
=================

Name: mem_stage_hs

Overview:
- Parametrised data-memory pipeline stage for the 5-stage core, between EX/MEM and the register-file writeback.
- Accepts one instruction per cycle from EX and issues a registered request/acknowledge transaction to a variable-latency data memory.
- Stalls upstream while a transaction is outstanding and forwards WB data into store data.
- Generates big-endian byte lanes for stores; aligns and sign/zero-extends loads; times out dead transactions.
- Drives the MEM/WB pipeline register.

Parameters:
- ADDR_W, 32, data address width.
- REG_AW, 5, register specifier width.
- TIMEOUT_CYC, 64, maximum WAIT cycles before bus error; 0 disables the timeout.

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction present from EX
- in_op  in  4  bit3 store, bit2 unsigned load, bits1:0 size (00 byte, 01 half, 10 word, 11 no memory access)
- in_addr  in  ADDR_W  effective address / ALU result
- in_alu_result  in  32  ALU result for non-memory ops
- in_store_data  in  32  rt value from EX
- in_rt_reg  in  REG_AW  rt specifier of store
- in_wreg  in  REG_AW  destination register
- in_do_wb  in  1  instruction writes back
- wb_fwd_en  in  1  WB stage writing
- wb_fwd_reg  in  REG_AW  WB destination
- wb_fwd_data  in  32  WB value
- stall  out  1  upstream must hold inputs
- dm_req  out  1  memory request
- dm_we  out  1  write request
- dm_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
- dm_be  out  4  byte enables; bit3 = byte lane [31:24]
- dm_wdata  out  32  write data
- dm_ack  in  1  memory completes request this cycle
- dm_rdata  in  32  read data, valid with dm_ack
- out_valid  out  1  MEM/WB entry valid
- out_wreg  out  REG_AW  destination
- out_do_wb  out  1  write enable to WB
- out_data  out  32  aligned load data or ALU result
- bus_err  out  1  one-cycle timeout pulse
- out_misalign  out  1  misalignment flag (see Optional Feature)

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0, including dm_req, stall, out_*, bus_err and the wait counter.
- Accept IDLE + in_valid + size 11: MEM/WB register loads in_alu_result / in_wreg / in_do_wb at the next edge; out_valid=1; no stall.
- Accept IDLE + in_valid + memory op:
  - stall=1 combinationally.
  - At the edge, register dm_addr={in_addr[ADDR_W-1:2],2'b00}, dm_we, dm_be, dm_wdata, op, byte offset, in_wreg.
  - dm_req=1; go to WAIT; out_valid=0.
- WAIT:
  - dm_req and all dm_* outputs stable.
  - stall = !dm_ack.
  - Counter increments each cycle.
- dm_ack in WAIT:
  - At the edge, out_data = aligned dm_rdata for loads.
  - out_do_wb = latched do_wb for loads, 0 for stores.
  - out_valid=1; dm_req=0; back to IDLE. Minimum memory-op latency: 2 cycles.
- Timeout: counter reaches TIMEOUT_CYC with no ack →
  - dm_req drops; bus_err=1 for one cycle.
  - out_valid=1 with out_do_wb=0; return to IDLE.
  - A dm_ack arriving in the same cycle takes priority over the timeout.
- Ack outside WAIT: ignored.
- Store forwarding: when wb_fwd_en && wb_fwd_reg==in_rt_reg && in_rt_reg!=0, store data = wb_fwd_data, else in_store_data. Evaluated at accept.
- Store lanes (big-endian):
  - SB: be=1000>>addr[1:0]; wdata = byte replicated ×4.
  - SH: be=1100 (addr[1]=0) or 0011; wdata = half replicated ×2.
  - SW: be=1111.
- Load lanes:
  - Byte: lane (3-addr[1:0]).
  - Half: addr[1]=0 → [31:16], else [15:0].
  - Sign- or zero-extended per bit2.
  - Word: dm_rdata unchanged.
- Without the feature: half ignores addr[0], word ignores addr[1:0].
- out_valid is a one-cycle pulse per retired instruction; it is 0 when in_valid=0.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Half with addr[0]=1, or word with addr[1:0]!=0, issues no dm_req and does not stall.
  - Next edge: out_valid=1, out_do_wb=0, out_misalign=1 (one cycle).
- Undefined: out_misalign tied 0; addresses aligned down as above.

Test Plan:
- LB at addr 0x101, dm_rdata=0x11F2_3344, ack after 3 WAIT cycles → stall high for 3 cycles; out_data=0xFFFF_FFF2, out_valid 1 cycle.
- SH at addr 0x202, rt=0x0000_BEEF, WB forwarding same reg with 0x1234_5678 → dm_be=0011, dm_wdata=0x5678_5678, dm_we=1, out_do_wb=0.
- ALU op, in_alu_result=0xCAFE → out_data=0xCAFE next edge, stall never asserted.
- LW, no ack for TIMEOUT_CYC=64 cycles → dm_req drops, bus_err pulses once, out_do_wb=0, next LW accepted.
- RESET asserted mid-WAIT → dm_req, stall, out_valid = 0 immediately; after release, LHU addr 0x2, rdata 0x1234_8001 → 0x0000_8001.
- With MISALIGN_TRAP_EN: LW at 0x3 → no dm_req, out_misalign=1, out_do_wb=0.

Source files
------------

// File: rtl/mem_stage_hs.sv
// Data-memory pipeline stage: EX/MEM -> req/ack data memory -> MEM/WB register.
// Optional build macro MISALIGN_TRAP_EN turns misaligned half/word accesses into traps.
module mem_stage_hs #(
  parameter int ADDR_W      = 32,
  parameter int REG_AW      = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              in_valid,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_alu_result,
  input  logic [31:0]       in_store_data,
  input  logic [REG_AW-1:0] in_rt_reg,
  input  logic [REG_AW-1:0] in_wreg,
  input  logic              in_do_wb,
  input  logic              wb_fwd_en,
  input  logic [REG_AW-1:0] wb_fwd_reg,
  input  logic [31:0]       wb_fwd_data,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic              out_valid,
  output logic [REG_AW-1:0] out_wreg,
  output logic              out_do_wb,
  output logic [31:0]       out_data,
  output logic              bus_err,
  output logic              out_misalign
);
  typedef enum logic {IDLE, WAIT} state_t;

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYC - 1);

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic              st_q, uns_q, dowb_q;
  logic [1:0]        size_q, off_q;
  logic [REG_AW-1:0] wreg_q;

  logic        is_mem, misal, accept_mem, tmo, fwd;
  logic [31:0] sdata, wdata_c, ldata;
  logic [3:0]  be_c;
  logic [7:0]  lb;
  logic [15:0] lh;

  assign is_mem = (in_op[1:0] != 2'b11);

`ifdef MISALIGN_TRAP_EN
  assign misal = (in_op[1:0] == 2'b01 && in_addr[0]) ||
                 (in_op[1:0] == 2'b10 && in_addr[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  assign accept_mem = (state == IDLE) && in_valid && is_mem && !misal;
  assign tmo = (TIMEOUT_CYC != 0) && (state == WAIT) && !dm_ack && (cnt == TLIM);

  // Timeout retires the instruction, so upstream must be released that cycle
  // or the dead access would be re-issued forever.
  assign stall = !RESET && (accept_mem || ((state == WAIT) && !dm_ack && !tmo));

  assign fwd   = wb_fwd_en && (wb_fwd_reg == in_rt_reg) && (in_rt_reg != '0);
  assign sdata = fwd ? wb_fwd_data : in_store_data;

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = sdata;
    case (in_op[1:0])
      2'b00: begin
        be_c    = 4'b1000 >> in_addr[1:0];
        wdata_c = {4{sdata[7:0]}};
      end
      2'b01: begin
        be_c    = in_addr[1] ? 4'b0011 : 4'b1100;
        wdata_c = {2{sdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lb = dm_rdata[31:24];
    case (off_q)
      2'd1:    lb = dm_rdata[23:16];
      2'd2:    lb = dm_rdata[15:8];
      2'd3:    lb = dm_rdata[7:0];
      default: ;
    endcase
    lh    = off_q[1] ? dm_rdata[15:0] : dm_rdata[31:16];
    ldata = dm_rdata;
    case (size_q)
      2'b00:   ldata = uns_q ? {24'b0, lb} : {{24{lb[7]}}, lb};
      2'b01:   ldata = uns_q ? {16'b0, lh} : {{16{lh[15]}}, lh};
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept_mem) state_nx = WAIT;
      WAIT:    if (dm_ack || tmo) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
      {st_q, uns_q, dowb_q} <= '0;
      size_q <= '0; off_q <= '0; wreg_q <= '0;
      dm_req <= 1'b0; dm_we <= 1'b0; dm_addr <= '0; dm_be <= '0; dm_wdata <= '0;
      out_valid <= 1'b0; out_wreg <= '0; out_do_wb <= 1'b0; out_data <= '0;
      bus_err <= 1'b0; out_misalign <= 1'b0;
    end else begin
      out_valid    <= 1'b0;
      out_do_wb    <= 1'b0;
      bus_err      <= 1'b0;
      out_misalign <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          if (!is_mem) begin
            out_valid <= 1'b1;
            out_data  <= in_alu_result;
            out_wreg  <= in_wreg;
            out_do_wb <= in_do_wb;
          end else if (misal) begin
            out_valid    <= 1'b1;
            out_data     <= '0;
            out_wreg     <= in_wreg;
            out_misalign <= 1'b1;
          end else begin
            dm_req   <= 1'b1;
            dm_we    <= in_op[3];
            dm_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
            dm_be    <= be_c;
            dm_wdata <= wdata_c;
            st_q     <= in_op[3];
            uns_q    <= in_op[2];
            size_q   <= in_op[1:0];
            off_q    <= in_addr[1:0];
            wreg_q   <= in_wreg;
            dowb_q   <= in_do_wb;
            cnt      <= '0;
          end
        end
        WAIT: begin
          if (dm_ack || tmo) begin
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_be     <= '0;
            out_valid <= 1'b1;
            out_wreg  <= wreg_q;
          end
          if (dm_ack) begin
            out_data  <= st_q ? 32'b0 : ldata;
            out_do_wb <= !st_q && dowb_q;
          end else if (tmo) begin
            out_data <= '0;
            bus_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
